// File: rtl/loop_sequencer.sv
// loop_sequencer: multi-channel step-pattern sequencer with a prescaled step clock and gated outputs.
// Ping-pong traversal (mode 2'b10) is built only when LOOP_SEQUENCER_PINGPONG_EN is defined; otherwise that mode runs forward.
module loop_sequencer #(
   parameter  int unsigned WIDTH       = 16,
   parameter  int unsigned CHANNELS    = 4,
   parameter  int unsigned PRESCALE    = 1000000,
   parameter  int unsigned GATE_CYCLES = 500000,
   localparam int unsigned PW          = $clog2(WIDTH),
   localparam int unsigned CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [1:0]          mode,
   input  logic [PW-1:0]       length,
   input  logic [CW-1:0]       sel,
   input  logic                set,
   input  logic                clear,
   output logic [PW-1:0]       pos,
   output logic                step_stb,
   output logic [CHANNELS-1:0] gate,
   output logic [WIDTH-1:0]    pattern_out
);

   localparam int unsigned    PSW        = $clog2(PRESCALE);
   localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);
   localparam logic [PSW:0]   GATE_LIM   = (PSW + 1)'(GATE_CYCLES);

   typedef enum logic [1:0] {
      MODE_FWD  = 2'b00,
      MODE_REV  = 2'b01,
      MODE_PING = 2'b10,
      MODE_HOLD = 2'b11
   } mode_e;

   logic [PSW-1:0]                 presc_q, presc_d;
   logic                           advance;
   logic [PW-1:0]                  pos_q, pos_d;
   logic                           stb_q, stb_d;
   logic [CHANNELS-1:0]            gate_q, gate_d;
   logic                           gate_open;
   logic [CHANNELS-1:0][WIDTH-1:0] pattern_q, pattern_d;
   logic [WIDTH-1:0]               pos_mask;
   mode_e                          mode_sel;

`ifdef LOOP_SEQUENCER_PINGPONG_EN
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
   dir_e dir_q, dir_d;
`endif

   assign mode_sel = mode_e'(mode);
   // One-hot of the current step; shifting past WIDTH yields zero, so out-of-range pos reads/writes nothing.
   assign pos_mask = WIDTH'(1) << pos_q;

   always_comb begin
      presc_d = presc_q;
      advance = 1'b0;
      if (run) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            advance = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_comb begin
      pos_d = pos_q;
      stb_d = 1'b0;
`ifdef LOOP_SEQUENCER_PINGPONG_EN
      dir_d = dir_q;
`endif
      if (advance) begin
         stb_d = 1'b1;
         case (mode_sel)
`ifdef LOOP_SEQUENCER_PINGPONG_EN
            MODE_PING: begin
               if (length == '0) begin
                  pos_d = '0;
               end else if (pos_q > length) begin
                  pos_d = length;
                  dir_d = DIR_DOWN;
               end else if (dir_q == DIR_UP) begin
                  if (pos_q >= length) begin
                     pos_d = length - 1'b1;
                     dir_d = DIR_DOWN;
                  end else begin
                     pos_d = pos_q + 1'b1;
                  end
               end else if (pos_q == '0) begin
                  pos_d = PW'(1);
                  dir_d = DIR_UP;
               end else begin
                  pos_d = pos_q - 1'b1;
               end
            end
`endif
            MODE_REV: begin
               if ((pos_q == '0) || (pos_q > length)) pos_d = length;
               else                                   pos_d = pos_q - 1'b1;
`ifdef LOOP_SEQUENCER_PINGPONG_EN
               dir_d = DIR_UP;
`endif
            end
            MODE_HOLD: pos_d = pos_q;
            default: begin
               if (pos_q >= length) pos_d = '0;
               else                 pos_d = pos_q + 1'b1;
`ifdef LOOP_SEQUENCER_PINGPONG_EN
               dir_d = DIR_UP;
`endif
            end
         endcase
      end
   end

   // Edits always target the pos registered this cycle, even if pos moves on the same edge.
   always_comb begin
      pattern_d = pattern_q;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (CW'(c) == sel) begin
            if (clear)    pattern_d[c] = pattern_q[c] & ~pos_mask;
            else if (set) pattern_d[c] = pattern_q[c] | pos_mask;
         end
      end
   end

   always_comb begin
      gate_open = ({1'b0, presc_q} < GATE_LIM);
      gate_d    = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         gate_d[c] = run & gate_open & (|(pattern_q[c] & pos_mask));
      end
   end

   always_comb begin
      pattern_out = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (CW'(c) == sel) pattern_out = pattern_q[c];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q   <= '0;
         pos_q     <= '0;
         stb_q     <= 1'b0;
         gate_q    <= '0;
         pattern_q <= '0;
      end else begin
         presc_q   <= presc_d;
         pos_q     <= pos_d;
         stb_q     <= stb_d;
         gate_q    <= gate_d;
         pattern_q <= pattern_d;
      end
   end

`ifdef LOOP_SEQUENCER_PINGPONG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dir_q <= DIR_UP;
      else      dir_q <= dir_d;
   end
`endif

   assign pos      = pos_q;
   assign step_stb = stb_q;
   assign gate     = gate_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed self-checking bench for loop_sequencer (WIDTH=8, CHANNELS=2, PRESCALE=4, GATE_CYCLES=2).
// Expected step positions are queued as stimulus is applied and popped on each step_stb.
module tb_loop_sequencer;

   localparam int unsigned W  = 8;
   localparam int unsigned CH = 2;
   localparam int unsigned PS = 4;
   localparam int unsigned GC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [1:0] mode;
   logic [2:0] length;
   logic       sel;
   logic       set;
   logic       clear;
   logic [2:0] pos;
   logic       step_stb;
   logic [1:0] gate;
   logic [7:0] pattern_out;

   int         checks = 0;
   int         fails  = 0;
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   loop_sequencer #(
      .WIDTH      (W),
      .CHANNELS   (CH),
      .PRESCALE   (PS),
      .GATE_CYCLES(GC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .mode       (mode),
      .length     (length),
      .sel        (sel),
      .set        (set),
      .clear      (clear),
      .pos        (pos),
      .step_stb   (step_stb),
      .gate       (gate),
      .pattern_out(pattern_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int unsigned v);
      exp_q.push_back(3'(v));
   endtask

   // Waits (bounded) for the next strobe, then checks pos against the queue and the cycle gap.
   task automatic next_step(input string tag, input int gap);
      int         n;
      logic [2:0] e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (step_stb !== 1'b1 && n < 40);
      chk({tag, "-stb"}, 32'(step_stb), 32'd1);
      if (step_stb === 1'b1) begin
         chk({tag, "-qdepth"}, 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "-pos"}, 32'(pos), 32'(e));
            if (gap > 0) chk({tag, "-gap"}, 32'(n), 32'(gap));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; run = 1'b0; set = 1'b0; clear = 1'b0;
      mode = 2'b00; length = 3'd7; sel = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_pos",  32'(pos), 32'd0);
      chk("rst_stb",  32'(step_stb), 32'd0);
      chk("rst_gate", 32'(gate), 32'd0);
      chk("rst_pat",  32'(pattern_out), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // forward loop 1..7,0,1 every 4 cycles
      run = 1'b1;
      for (int i = 1; i <= 7; i++) push(i);
      push(0); push(1);
      repeat (9) next_step("fwd", 4);

      // edit channel 1: set at pos 3, set+clear at pos 5
      push(2); push(3);
      next_step("to3", 4);
      next_step("to3", 4);
      set = 1'b1;
      @(negedge clk);
      set = 1'b0;
      push(4); push(5);
      next_step("to5", 3);
      next_step("to5", 4);
      set = 1'b1; clear = 1'b1;
      @(negedge clk);
      set = 1'b0; clear = 1'b0;
      chk("pat_clrwins", 32'(pattern_out), 32'h08);
      sel = 1'b0;
      #1 chk("pat_ch0", 32'(pattern_out), 32'h00);
      sel = 1'b1;

      // revisit pos 3: gate[1] high for exactly two cycles
      push(6); push(7); push(0); push(1); push(2); push(3);
      next_step("wrap", 3);
      repeat (5) next_step("wrap", 4);
      chk("gate_n0", 32'(gate), 32'h0);
      @(negedge clk); chk("gate_n1", 32'(gate), 32'h2);
      @(negedge clk); chk("gate_n2", 32'(gate), 32'h2);
      @(negedge clk); chk("gate_n3", 32'(gate), 32'h0);
      push(4);
      next_step("to4", 1);

      // length 3, then ping-pong
      length = 3'd3;
      push(0);
      next_step("len3", 4);
      mode = 2'b10;
`ifdef LOOP_SEQUENCER_PINGPONG_EN
      push(1); push(2); push(3); push(2); push(1); push(0); push(1);
      repeat (7) next_step("pp", 4);
`else
      push(1); push(2); push(3); push(0); push(1);
      repeat (5) next_step("pp", 4);
`endif

      // length shrink below pos: forward and reverse
      mode = 2'b00; length = 3'd7;
      for (int i = 2; i <= 6; i++) push(i);
      repeat (5) next_step("fwd2", 4);
      length = 3'd4;
      push(0);
      next_step("shrink_fwd", 4);
      length = 3'd7;
      for (int i = 1; i <= 6; i++) push(i);
      repeat (6) next_step("fwd3", 4);
      mode = 2'b01; length = 3'd4;
      push(4); push(3); push(2); push(1); push(0); push(4);
      repeat (6) next_step("rev", 4);

      // length 0 holds pos at 0 but still strobes
      length = 3'd0;
      push(0); push(0);
      repeat (2) next_step("len0", 4);
      mode = 2'b10;
      push(0);
      next_step("len0pp", 4);

      // hold mode
      mode = 2'b00; length = 3'd7;
      push(1); push(2);
      repeat (2) next_step("fwd4", 4);
      mode = 2'b11;
      push(2); push(2);
      repeat (2) next_step("hold", 4);
      mode = 2'b00;
      push(3);
      next_step("to3b", 4);

      // run=0 freezes position and forces gates low
      @(negedge clk);
      chk("gate_pre_stop", 32'(gate), 32'h2);
      run = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("stop_gate", 32'(gate), 32'h0);
         chk("stop_stb",  32'(step_stb), 32'd0);
         chk("stop_pos",  32'(pos), 32'd3);
      end
      run = 1'b1;
      push(4);
      next_step("resume", 3);

      // asynchronous reset between edges while gate is high
      push(5); push(6); push(7); push(0); push(1); push(2); push(3);
      repeat (7) next_step("fwd5", 4);
      @(negedge clk);
      chk("gate_pre_rst", 32'(gate), 32'h2);
      #2 rst = 1'b0;
      #1;
      chk("arst_gate", 32'(gate), 32'h0);
      chk("arst_pos",  32'(pos), 32'd0);
      chk("arst_stb",  32'(step_stb), 32'd0);
      chk("arst_pat1", 32'(pattern_out), 32'h00);
      sel = 1'b0;
      #1 chk("arst_pat0", 32'(pattern_out), 32'h00);
      sel = 1'b1;
      @(negedge clk);
      chk("rst_hold_stb", 32'(step_stb), 32'd0);
      rst = 1'b1;
      push(1);
      next_step("post_rst", 4);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
